// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a synchronous RAM and presents
// each fetched word to the core through a valid/ready handshake.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [1:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   ir_out_q, ir_out_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      lat_q      <= '0;
      ir_out_q   <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lat_q      <= lat_d;
      ir_out_q   <= ir_out_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // halt outranks redirect; a HOLD word taken in the same cycle as a redirect
  // has already been consumed, so only the refetch matters here.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lat_d      = lat_q;
    ir_out_d   = ir_out_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (halt) begin
      state_d    = S_IDLE;
      ir_valid_d = 1'b0;
    end else if (redirect && (state_q != S_IDLE)) begin
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      lat_d      = '0;
      state_d    = S_REQ;
    end else begin
      case (state_q)
        S_IDLE: begin
          ir_valid_d = 1'b0;
          if (start) begin
            pc_d    = start_pc;
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          lat_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            ir_out_d   = ram_r_data;
            ir_pc_d    = pc_q;
            pc_d       = pc_q + 1'b1;
            ir_valid_d = 1'b1;
            state_d    = S_HOLD;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ram_r_addr = pc_q;
  assign ir_out     = ir_out_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected (pc, word) pairs are queued
// by the stimulus and popped by a monitor on every accepted transfer.
module tb_instr_fetch_unit;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int RAM_LAT = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n, start, redirect, halt, ir_ready;
  logic [ADDR_W-1:0] start_pc, redirect_pc, ram_r_addr, ir_pc;
  logic [DATA_W-1:0] ram_r_data, ir_out;
  logic              ir_valid, busy;

  logic [DATA_W-1:0] mem [256];
  logic [ADDR_W-1:0] apipe [RAM_LAT];
  exp_t              q [$];
  int                checks = 0;
  int                passes = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with RAM_LAT cycles from address to data.
  always @(posedge clk) begin
    apipe[0] <= ram_r_addr;
    for (int i = 1; i < RAM_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign ram_r_data = mem[apipe[RAM_LAT-1]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [ADDR_W-1:0] s, input int n);
    exp_t e;
    logic [ADDR_W-1:0] a;
    a = s;
    for (int i = 0; i < n; i++) begin
      e.pc   = a;
      e.data = mem[a];
      q.push_back(e);
      a = a + 1'b1;
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] s);
    start    = 1'b1;
    start_pc = s;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!ir_valid && n < 50) begin
      tick();
      n++;
    end
    if (!ir_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Runs until the scoreboard empties; random mode stalls ir_ready and pokes
  // start, which must be ignored while busy.
  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
      if (q.size() == 0) break;
      if (rnd) begin
        ir_ready = ($urandom_range(0, 3) != 0);
        start    = $urandom_range(0, 1) == 1;
        start_pc = 8'($urandom);
      end
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    ir_ready = 1'b0;
    start    = 1'b0;
  endtask

  task automatic stop();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_valid", {31'd0, ir_valid}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready && !halt) begin
      if (q.size() == 0) begin
        check("unexpected_xfer_pc", {24'd0, ir_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("xfer_pc", {24'd0, ir_pc}, {24'd0, e.pc});
        check("xfer_data", {16'd0, ir_out}, {16'd0, e.data});
      end
    end
  end

  initial begin
    int n;
    logic [ADDR_W-1:0] s, r;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'hA5A5;
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; halt = 1'b0; ir_ready = 1'b0;
    start_pc = '0; redirect_pc = '0;
    tick(); tick();
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {24'd0, ram_r_addr}, 32'd0);
    check("rst_ir_out", {16'd0, ir_out}, 32'd0);
    check("rst_ir_pc", {24'd0, ir_pc}, 32'd0);
    rst_n = 1'b1;
    tick();

    // First fetch latency, then a 5-cycle stall in HOLD.
    push_run(8'h10, 1);
    do_start(8'h10);
    wait_valid(n);
    check("first_latency", n, 2 + RAM_LAT);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, ir_valid}, 32'd1);
      check("stall_ir_out", {16'd0, ir_out}, 32'h0000_A5A5);
      check("stall_ir_pc", {24'd0, ir_pc}, 32'h10);
      check("stall_addr", {24'd0, ram_r_addr}, 32'h11);
      tick();
    end
    push_run(8'h11, 1);
    ir_ready = 1'b1;
    drain(1'b0);
    stop();

    // Redirect during WAIT: the word from 0x20 must never be transferred.
    ir_ready = 1'b1;
    push_run(8'h40, 3);
    do_start(8'h20);
    tick();
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    drain(1'b0);
    stop();

    // PC wraps from 0xFF to 0x00.
    ir_ready = 1'b1;
    push_run(8'hFF, 2);
    do_start(8'hFF);
    drain(1'b0);
    stop();

    // halt and redirect together in HOLD: halt wins, pc is kept.
    s = 8'($urandom);
    do_start(s);
    wait_valid(n);
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = s ^ 8'h5A;
    tick();
    halt     = 1'b0;
    redirect = 1'b0;
    check("hr_valid", {31'd0, ir_valid}, 32'd0);
    check("hr_busy", {31'd0, busy}, 32'd0);
    check("hr_pc_kept", {24'd0, ram_r_addr}, {24'd0, s + 8'd1});
    tick();
    check("hr_still_idle", {31'd0, busy}, 32'd0);
    r = 8'($urandom);
    ir_ready = 1'b1;
    push_run(r, 2);
    do_start(r);
    drain(1'b0);
    stop();

    // Reset in the middle of WAIT, with start held high throughout.
    do_start(8'h33);
    tick();
    rst_n = 1'b0;
    start = 1'b1;
    start_pc = 8'h77;
    tick();
    check("mrst_valid", {31'd0, ir_valid}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_addr", {24'd0, ram_r_addr}, 32'd0);
    check("mrst_ir_out", {16'd0, ir_out}, 32'd0);
    check("mrst_ir_pc", {24'd0, ir_pc}, 32'd0);
    tick(); tick();
    check("mrst_hold_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    check("mrst_after_busy", {31'd0, busy}, 32'd0);

    // Random episodes: fetch, stall, redirect in REQ/WAIT/HOLD, refetch.
    for (int ep = 0; ep < 30; ep++) begin
      s = 8'($urandom);
      push_run(s, $urandom_range(1, 3));
      do_start(s);
      drain(1'b1);
      repeat ($urandom_range(0, RAM_LAT + 2)) tick();
      r = 8'($urandom);
      push_run(r, $urandom_range(1, 4));
      redirect    = 1'b1;
      redirect_pc = r;
      tick();
      redirect = 1'b0;
      drain(1'b1);
      stop();
    end

    check("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
